icap_reboot_master: RTL and testbench
=====================================

Name: icap_reboot_master

Overview:
- Wishbone initiator that drives the 8-bit ICAP Wishbone responder.
- On a `go` pulse it streams the Spartan-3A IPROG command sequence to the ICAP port, one byte per Wishbone write. The sequence is: sync, GENERAL1–4 multiboot/fallback addresses, CMD REBOOT, NOOPs.
- It sits between the settings bus / firmware trigger and the ICAP responder and performs the software-commanded reload from a chosen flash address.

Parameters:
- RD_OPCODE, 8'h0B, SPI flash read opcode placed in the GENERAL2/GENERAL4 high bytes.
- GOLDEN_ADDR, 24'h000000, fallback flash address written to GENERAL3/GENERAL4.
- BITSWAP, 1, 1 = bit-reverse each byte onto dat_o[7:0] (ICAP bit order); 0 = pass straight.
- ACK_TIMEOUT, 16, cycles allowed per write before abort (used only with ICAP_ACK_TIMEOUT_EN).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- go  in  1  start request, sampled in IDLE only
- boot_addr  in  24  multiboot flash address, latched when go is accepted
- busy  out  1  high from accept until DONE or abort
- done  out  1  one-cycle pulse after final ack
- err  out  1  sticky timeout flag; 0 when option absent
- cyc_o  out  1  Wishbone cycle
- stb_o  out  1  Wishbone strobe
- we_o  out  1  write enable, always 1 during a transfer
- dat_o  out  32  write data; [31:8]=0, [7:0]=byte
- ack_i  in  1  Wishbone acknowledge
- dat_i  in  32  read data; unused, ignored

Behaviour:
- Reset: asserting reset_n=0 immediately forces IDLE.
  - Clears busy, done, err, cyc_o, stb_o, we_o, dat_o, and the byte counter.
  - All outputs are registered.
  - Reset mid-sequence abandons the transfer with no further strobes.
- Word sequence (16-bit, index 0..13):
  - 0: FFFF
  - 1: AA99
  - 2: 3261
  - 3: boot_addr[15:0]
  - 4: 3281
  - 5: {RD_OPCODE, boot_addr[23:16]}
  - 6: 32A1
  - 7: GOLDEN_ADDR[15:0]
  - 8: 32C1
  - 9: {RD_OPCODE, GOLDEN_ADDR[23:16]}
  - 10: 30A1
  - 11: 000E
  - 12: 2000
  - 13: 2000
- Byte order: each word is sent high byte first, then low byte. That gives 28 bytes, indexed by a 5-bit counter 0..27.
- FSM states: IDLE, REQ, GAP, DONE.
  - IDLE: when go=1, latch boot_addr, set busy, clear err, counter=0, go to REQ. cyc_o/stb_o/we_o rise on this edge and dat_o carries byte 0.
  - REQ: hold cyc/stb/we and dat_o stable until ack_i=1. On the edge sampling ack: deassert cyc/stb/we and increment the counter. If the counter was 27, go to DONE; else go to GAP.
  - GAP: exactly one cycle with cyc/stb low, then load the next byte and return to REQ with strobes raised.
  - DONE: done=1 for one cycle, busy=0, return to IDLE.
- Timing against the ICAP responder (ack 2 cycles after strobe seen):
  - 4 clocks per byte.
  - done is high 112 clocks after the go-accept edge.
- go while busy: ignored.
- go held high through DONE: a new sequence starts on the next IDLE cycle (level-sampled).
- ack_i outside REQ: ignored.
- A multi-cycle ack counts once; strobes are already dropped.
- dat_o[7:0] with BITSWAP=1 is {b[0],b[1],...,b[7]} of the sequence byte.

Optional Feature:
- Macro: ICAP_ACK_TIMEOUT_EN.
- Defined:
  - A per-transfer counter resets on strobe rise and counts REQ cycles.
  - If it reaches ACK_TIMEOUT without ack_i, the block drops cyc/stb/we, sets err=1 (sticky until next accepted go), clears busy, and returns to IDLE.
  - No done pulse in that case.
- Undefined:
  - No counter logic; REQ waits indefinitely.
  - err is tied to 0.

Test Plan:
- Reset with go=1, then release reset_n: all outputs 0; go sampled on the first edge after release; busy=1.
- go with boot_addr=24'h0C0000 and BITSWAP=0 against a 2-cycle-ack model: 28 writes with bytes FF,FF,AA,99,32,61,00,00,32,81,0B,0C,32,A1,00,00,32,C1,0B,00,30,A1,00,0E,20,00,20,00. done pulses at clock 112; busy then low.
- BITSWAP=1: byte AA appears as 8'h55 and 61 as 8'h86; dat_o[31:8]=0 throughout.
- go re-pulsed during byte 10 is ignored; a responder holding ack for 3 cycles yields exactly 28 transfers.
- reset_n low during byte 15: cyc_o/stb_o drop asynchronously. After release, a new go restarts from FFFF.
- ICAP_ACK_TIMEOUT_EN, ACK_TIMEOUT=16, responder never acks byte 4: strobe drops after 16 cycles, err=1, no done. The next go clears err and completes normally.

Source files
------------

// File: rtl/icap_reboot_master.sv
// Wishbone initiator that streams the Spartan-3A IPROG reboot sequence, one byte per write, to an 8-bit ICAP responder.
// Optional macro ICAP_ACK_TIMEOUT_EN adds a per-write ack timeout with a sticky err flag.
module icap_reboot_master #(
   parameter logic [7:0]  RD_OPCODE   = 8'h0B,
   parameter logic [23:0] GOLDEN_ADDR = 24'h000000,
   parameter int          BITSWAP     = 1,
   parameter int          ACK_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        go,
   input  logic [23:0] boot_addr,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] dat_o,
   input  logic        ack_i,
   input  logic [31:0] dat_i,
   output logic [1:0]  dbg_state
);

   // Handshake: a write is offered while cyc_o=stb_o=1 and completes on the first
   // cycle ack_i rises in REQ; strobes drop on that same edge, so a held ack counts once.
   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP, ST_DONE} state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [23:0] addr_q, addr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        cyc_q, cyc_d;
   logic        stb_q, stb_d;
   logic        we_q, we_d;
   logic [7:0]  dat_q, dat_d;
   logic        ack_prev_q, ack_prev_d;
   logic        ack_ok;
   logic        unused_bits;

`ifdef ICAP_ACK_TIMEOUT_EN
   logic        err_q, err_d;
   logic [15:0] tmo_q, tmo_d;
`endif

   function automatic logic [15:0] seq_word(input logic [3:0] idx, input logic [23:0] addr);
      logic [15:0] w;
      case (idx)
         4'd0:    w = 16'hFFFF;
         4'd1:    w = 16'hAA99;
         4'd2:    w = 16'h3261;
         4'd3:    w = addr[15:0];
         4'd4:    w = 16'h3281;
         4'd5:    w = {RD_OPCODE, addr[23:16]};
         4'd6:    w = 16'h32A1;
         4'd7:    w = GOLDEN_ADDR[15:0];
         4'd8:    w = 16'h32C1;
         4'd9:    w = {RD_OPCODE, GOLDEN_ADDR[23:16]};
         4'd10:   w = 16'h30A1;
         4'd11:   w = 16'h000E;
         4'd12:   w = 16'h2000;
         4'd13:   w = 16'h2000;
         default: w = 16'h0000;
      endcase
      return w;
   endfunction

   // High byte of each word goes out first.
   function automatic logic [7:0] seq_byte(input logic [4:0] idx, input logic [23:0] addr);
      logic [15:0] w;
      w = seq_word(idx[4:1], addr);
      return idx[0] ? w[7:0] : w[15:8];
   endfunction

   function automatic logic [7:0] icap_order(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return (BITSWAP != 0) ? r : b;
   endfunction

   assign ack_ok = ack_i && !ack_prev_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      we_d       = we_q;
      dat_d      = dat_q;
      ack_prev_d = ack_i;
`ifdef ICAP_ACK_TIMEOUT_EN
      err_d      = err_q;
      tmo_d      = tmo_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (go) begin
               addr_d  = boot_addr;
               busy_d  = 1'b1;
               cnt_d   = 5'd0;
               cyc_d   = 1'b1;
               stb_d   = 1'b1;
               we_d    = 1'b1;
               dat_d   = icap_order(seq_byte(5'd0, boot_addr));
               state_d = ST_REQ;
`ifdef ICAP_ACK_TIMEOUT_EN
               err_d   = 1'b0;
               tmo_d   = 16'd0;
`endif
            end
         end
         ST_REQ: begin
            if (ack_ok) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               cnt_d   = cnt_q + 5'd1;
               state_d = (cnt_q == 5'd27) ? ST_DONE : ST_GAP;
            end
`ifdef ICAP_ACK_TIMEOUT_EN
            else if (tmo_q == 16'(ACK_TIMEOUT - 1)) begin
               cyc_d   = 1'b0;
               stb_d   = 1'b0;
               we_d    = 1'b0;
               err_d   = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               tmo_d   = tmo_q + 16'd1;
            end
`endif
         end
         ST_GAP: begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = 1'b1;
            dat_d   = icap_order(seq_byte(cnt_q, addr_q));
            state_d = ST_REQ;
`ifdef ICAP_ACK_TIMEOUT_EN
            tmo_d   = 16'd0;
`endif
         end
         ST_DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 5'd0;
         addr_q     <= 24'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cyc_q      <= 1'b0;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         dat_q      <= 8'd0;
         ack_prev_q <= 1'b0;
`ifdef ICAP_ACK_TIMEOUT_EN
         err_q      <= 1'b0;
         tmo_q      <= 16'd0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cyc_q      <= cyc_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         dat_q      <= dat_d;
         ack_prev_q <= ack_prev_d;
`ifdef ICAP_ACK_TIMEOUT_EN
         err_q      <= err_d;
         tmo_q      <= tmo_d;
`endif
      end
   end

`ifdef ICAP_ACK_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign busy      = busy_q;
   assign done      = done_q;
   assign cyc_o     = cyc_q;
   assign stb_o     = stb_q;
   assign we_o      = we_q;
   assign dat_o     = {24'd0, dat_q};
   assign dbg_state = state_q;

   // The responder's read data carries nothing for a write-only master.
   assign unused_bits = ^{dat_i, 32'(ACK_TIMEOUT)};

endmodule

// File: tb/tb_icap_reboot_master.sv
// Directed bench for icap_reboot_master: two DUTs (BITSWAP 0 and 1) share one 2-cycle-ack responder;
// a scoreboard queue holds the expected byte stream and is checked at every strobe rise.
module tb_icap_reboot_master;

   logic        clk;
   logic        reset_n;
   logic        go;
   logic [23:0] boot_addr;
   logic        ack;
   logic [31:0] dat_in;

   logic        busy0, done0, err0, cyc0, stb0, we0;
   logic [31:0] dat0;
   logic [1:0]  st0;
   logic        busy1, done1, err1, cyc1, stb1, we1;
   logic [31:0] dat1;
   logic [1:0]  st1;

   icap_reboot_master #(.BITSWAP(0)) dut0 (
      .clk(clk), .reset_n(reset_n), .go(go), .boot_addr(boot_addr),
      .busy(busy0), .done(done0), .err(err0), .cyc_o(cyc0), .stb_o(stb0), .we_o(we0),
      .dat_o(dat0), .ack_i(ack), .dat_i(dat_in), .dbg_state(st0)
   );

   icap_reboot_master #(.BITSWAP(1)) dut1 (
      .clk(clk), .reset_n(reset_n), .go(go), .boot_addr(boot_addr),
      .busy(busy1), .done(done1), .err(err1), .cyc_o(cyc1), .stb_o(stb1), .we_o(we1),
      .dat_o(dat1), .ack_i(ack), .dat_i(dat_in), .dbg_state(st1)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc_n = 0;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   // ---------------- responder model ----------------
   int   resp_hold  = 1;
   int   no_ack_idx = -1;
   int   xfer_total = 0;
   int   base       = 0;
   int   r_phase;
   int   r_left;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack     <= 1'b0;
         r_phase <= 0;
         r_left  <= 0;
      end else begin
         case (r_phase)
            0: if (cyc0 && stb0 && (xfer_total - base - 1) != no_ack_idx) r_phase <= 1;
            1: begin
               ack     <= 1'b1;
               r_left  <= resp_hold;
               r_phase <= 2;
            end
            default: begin
               if (r_left <= 1) begin
                  ack     <= 1'b0;
                  r_phase <= 0;
               end else begin
                  r_left <= r_left - 1;
               end
            end
         endcase
      end
   end

   // ---------------- scoreboard ----------------
   logic [7:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;
   int done_cnt = 0;
   int done_t = 0;
   logic stb_prev = 1'b0;
   int t0, tr, d0, k;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rev8(input logic [7:0] b);
      return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
   endfunction

   task automatic push_seq(input logic [23:0] a);
      logic [15:0] w [14];
      w = '{16'hFFFF, 16'hAA99, 16'h3261, a[15:0], 16'h3281, {8'h0B, a[23:16]},
            16'h32A1, 16'h0000, 16'h32C1, 16'h0B00, 16'h30A1, 16'h000E, 16'h2000, 16'h2000};
      for (int i = 0; i < 14; i++) begin
         exp_q.push_back(w[i][15:8]);
         exp_q.push_back(w[i][7:0]);
      end
   endtask

   // One clock step; every strobe rise pops one expected byte.
   task automatic tick();
      logic [7:0] e;
      @(negedge clk);
      if (stb0 && !stb_prev) begin
         xfer_total++;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
         chk("byte_plain", {24'd0, dat0[7:0]}, {24'd0, e});
         chk("upper_zero", {8'd0, dat0[31:8]}, 32'd0);
         chk("byte_swapped", dat1, {24'd0, rev8(e)});
         chk("we_during_stb", {31'd0, we0}, 32'd1);
      end
      stb_prev = stb0;
      if (done0) begin
         done_cnt++;
         done_t = cyc_n;
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic start(input logic [23:0] a);
      boot_addr = a;
      go = 1'b1;
      push_seq(a);
      base = xfer_total;
      tick();
      go = 1'b0;
      t0 = cyc_n;
   endtask

   task automatic wait_xfer(input int n, input int budget);
      int i;
      i = 0;
      while ((xfer_total - base) < n && i < budget) begin
         tick();
         i++;
      end
      chk("wait_xfer", 32'(xfer_total - base), 32'(n));
   endtask

   task automatic wait_done(input int budget);
      int i;
      int d;
      i = 0;
      d = done_cnt;
      while (done_cnt == d && i < budget) begin
         tick();
         i++;
      end
      chk("done_seen", 32'(done_cnt - d), 32'd1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset_n = 1'b0;
      go = 1'b1;
      boot_addr = 24'h0C0000;
      dat_in = 32'hDEAD_BEEF;

      // Reset held with go high: everything quiet.
      repeat (3) tick();
      chk("rst_busy", {31'd0, busy0}, 32'd0);
      chk("rst_done", {31'd0, done0}, 32'd0);
      chk("rst_err", {31'd0, err0}, 32'd0);
      chk("rst_cyc", {31'd0, cyc0}, 32'd0);
      chk("rst_stb", {31'd0, stb0}, 32'd0);
      chk("rst_we", {31'd0, we0}, 32'd0);
      chk("rst_dat", dat0, 32'd0);
      chk("rst_state", {30'd0, st0}, 32'd0);

      // Release: go sampled on the first edge after release.
      push_seq(24'h0C0000);
      base = xfer_total;
      reset_n = 1'b1;
      tick();
      go = 1'b0;
      t0 = cyc_n;
      chk("accept_busy", {31'd0, busy0}, 32'd1);
      chk("accept_cyc", {31'd0, cyc0}, 32'd1);
      wait_done(300);
      chk("done_latency", 32'(done_t - t0), 32'd112);
      chk("busy_at_done", {31'd0, busy0}, 32'd0);
      chk("xfers_seq1", 32'(xfer_total - base), 32'd28);
      chk("queue_empty1", 32'(exp_q.size()), 32'd0);
      tick();
      chk("done_one_cycle", {31'd0, done0}, 32'd0);
      chk("busy_after", {31'd0, busy0}, 32'd0);

      // Long ack (3 cycles) plus a stray go during byte 10.
      resp_hold = 3;
      start(24'h123456);
      wait_xfer(11, 200);
      boot_addr = 24'hFFFFFF;
      go = 1'b1;
      tick();
      go = 1'b0;
      chk("busy_ignored_go", {31'd0, busy0}, 32'd1);
      wait_done(800);
      chk("xfers_seq2", 32'(xfer_total - base), 32'd28);
      chk("queue_empty2", 32'(exp_q.size()), 32'd0);
      resp_hold = 1;
      repeat (4) tick();

      // Reset during byte 15: strobes drop without a clock edge.
      start(24'hA1B2C3);
      wait_xfer(16, 200);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_cyc", {31'd0, cyc0}, 32'd0);
      chk("async_stb", {31'd0, stb0}, 32'd0);
      chk("async_busy", {31'd0, busy0}, 32'd0);
      exp_q.delete();
      repeat (3) tick();
      reset_n = 1'b1;
      repeat (2) tick();
      chk("post_rst_stb", {31'd0, stb0}, 32'd0);
      start(24'h0C0000);
      wait_done(300);
      chk("done_latency_rst", 32'(done_t - t0), 32'd112);
      chk("xfers_seq3", 32'(xfer_total - base), 32'd28);
      chk("queue_empty3", 32'(exp_q.size()), 32'd0);
      repeat (2) tick();

`ifdef ICAP_ACK_TIMEOUT_EN
      // Responder never acks byte 4.
      no_ack_idx = 4;
      start(24'h000100);
      wait_xfer(5, 100);
      tr = cyc_n;
      k = 0;
      while (stb0 && k < 40) begin
         tick();
         k++;
      end
      chk("tmo_len", 32'(cyc_n - tr), 32'd16);
      chk("tmo_err", {31'd0, err0}, 32'd1);
      chk("tmo_busy", {31'd0, busy0}, 32'd0);
      d0 = done_cnt;
      repeat (10) tick();
      chk("tmo_no_done", 32'(done_cnt - d0), 32'd0);
      chk("tmo_xfers", 32'(xfer_total - base), 32'd5);
      chk("tmo_err_sticky", {31'd0, err0}, 32'd1);
      exp_q.delete();
      no_ack_idx = -1;
      start(24'h0C0000);
      chk("err_cleared", {31'd0, err0}, 32'd0);
      wait_done(300);
      chk("xfers_after_tmo", 32'(xfer_total - base), 32'd28);
      chk("queue_empty4", 32'(exp_q.size()), 32'd0);
`else
      chk("err_tied0", {31'd0, err0}, 32'd0);
      chk("err_tied1", {31'd0, err1}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
